// File: rtl/my_dmux8way16_buf.sv
// my_dmux8way16_buf: 1-to-8 demultiplexer of 16-bit words with a one-word
// buffer slot per output channel and ready/valid handshaking on both sides.
// Each channel drains independently. Incoming words are steered by sel.
// Optional feature: define MY_DMUX8WAY16_BCAST_EN to add the bcast input.
// When bcast is high, one accepted word is written into all eight slots.
module my_dmux8way16_buf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  in,
  input  logic [2:0]   sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [3:0]   occupancy
`ifdef MY_DMUX8WAY16_BCAST_EN
  ,
  input  logic         bcast
`endif
);

  localparam int DATA_W = 16;
  localparam int CHANS  = 8;

  logic [CHANS-1:0][DATA_W-1:0] slot_q;
  logic [CHANS-1:0]             valid_q;
  logic [CHANS-1:0]             valid_d;
  logic [CHANS-1:0]             load_d;
  logic [CHANS-1:0]             free;
  logic [3:0]                   occ_q;
  logic [3:0]                   occ_d;
  logic                         accept;

  function automatic logic [3:0] popcount8(input logic [CHANS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < CHANS; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // A slot can take a word if it is empty or is being drained this cycle.
  // Routing, next-state valid flags and next-state occupancy.
  always_comb begin
    free     = ~valid_q | out_ready;
    in_ready = free[sel];
    load_d   = '0;
`ifdef MY_DMUX8WAY16_BCAST_EN
    if (bcast) begin
      in_ready = &free;
    end
`endif
    accept = in_valid & in_ready;
    if (accept) begin
      load_d = CHANS'(1) << sel;
`ifdef MY_DMUX8WAY16_BCAST_EN
      if (bcast) begin
        load_d = '1;
      end
`endif
    end
    // A draining slot empties unless it is reloaded in the same cycle.
    valid_d = (valid_q & ~out_ready) | load_d;
    occ_d   = popcount8(valid_d);
  end

  // Slot data, valid flags and occupancy; reset empties every slot at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      valid_q <= '0;
      occ_q   <= 4'd0;
    end else begin
      for (int k = 0; k < CHANS; k++) begin
        if (load_d[k]) begin
          slot_q[k] <= in;
        end
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out_data  = slot_q;
  assign out_valid = valid_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_my_dmux8way16_buf.sv
// Directed testbench for my_dmux8way16_buf. The broadcast test is built
// only when MY_DMUX8WAY16_BCAST_EN is defined.
module tb_my_dmux8way16_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in;
  logic [2:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [3:0]   occupancy;
  logic         bcast;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  my_dmux8way16_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef MY_DMUX8WAY16_BCAST_EN
    ,
    .bcast     (bcast)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 8'h00;
    bcast     = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic load(input logic [2:0] s, input logic [15:0] d);
    sel = s; in = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in = 16'h0; sel = 3'd0; in_valid = 1'b0;
    out_ready = 8'h00; bcast = 1'b0;
    #12;
    checks++; if (out_valid !== 8'h00) begin fails++; $display("FAIL reset_out_valid got=%h exp=00", out_valid); end
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_accept;
    do_reset();
    load(3'd3, 16'hA5A5);
    checks++; if (out_valid !== 8'h08) begin fails++; $display("FAIL single_out_valid got=%h exp=08", out_valid); end
    checks++; if (out_data[63:48] !== 16'hA5A5) begin fails++; $display("FAIL single_lane3 got=%h exp=a5a5", out_data[63:48]); end
    checks++; if (occupancy !== 4'd1) begin fails++; $display("FAIL single_occupancy got=%0d exp=1", occupancy); end
  endtask

  task automatic test_idle;
    do_reset();
    load(3'd1, 16'h0101);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i * 2 + 1); in = 16'hDEAD;
      tick();
    end
    checks++; if (out_valid !== 8'h02) begin fails++; $display("FAIL idle_out_valid got=%h exp=02", out_valid); end
    checks++; if (out_data[31:16] !== 16'h0101) begin fails++; $display("FAIL idle_lane1 got=%h exp=0101", out_data[31:16]); end
    checks++; if (occupancy !== 4'd1) begin fails++; $display("FAIL idle_occupancy got=%0d exp=1", occupancy); end
  endtask

  task automatic test_backpressure;
    do_reset();
    load(3'd5, 16'h5555);
    out_ready = 8'h00;
    sel = 3'd5; in = 16'h1111; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 8'h20) begin fails++; $display("FAIL bp_hold_valid got=%h exp=20", out_valid); end
    checks++; if (out_data[95:80] !== 16'h5555) begin fails++; $display("FAIL bp_hold_lane5 got=%h exp=5555", out_data[95:80]); end
    sel = 3'd2; in = 16'h2222;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_other got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 8'h24) begin fails++; $display("FAIL bp_other_valid got=%h exp=24", out_valid); end
    checks++; if (occupancy !== 4'd2) begin fails++; $display("FAIL bp_occupancy got=%0d exp=2", occupancy); end
    checks++; if (out_data[47:32] !== 16'h2222) begin fails++; $display("FAIL bp_lane2 got=%h exp=2222", out_data[47:32]); end
    checks++; if (out_data[95:80] !== 16'h5555) begin fails++; $display("FAIL bp_lane5_kept got=%h exp=5555", out_data[95:80]); end
  endtask

  task automatic test_pass_through;
    do_reset();
    load(3'd0, 16'h0BAD);
    out_ready = 8'h01;
    sel = 3'd0; in = 16'h1234; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL pt_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    checks++; if (out_valid !== 8'h01) begin fails++; $display("FAIL pt_out_valid got=%h exp=01", out_valid); end
    checks++; if (out_data[15:0] !== 16'h1234) begin fails++; $display("FAIL pt_lane0 got=%h exp=1234", out_data[15:0]); end
    checks++; if (occupancy !== 4'd1) begin fails++; $display("FAIL pt_occupancy got=%0d exp=1", occupancy); end
  endtask

  task automatic test_drain_all;
    logic [15:0] exp_w;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      load(3'(k), 16'h1000 + 16'(k) * 16'h0101);
    end
    checks++; if (out_valid !== 8'hFF) begin fails++; $display("FAIL fill_out_valid got=%h exp=ff", out_valid); end
    checks++; if (occupancy !== 4'd8) begin fails++; $display("FAIL fill_occupancy got=%0d exp=8", occupancy); end
    for (int k = 0; k < 8; k++) begin
      exp_w = 16'h1000 + 16'(k) * 16'h0101;
      checks++; if (out_data[16*k +: 16] !== exp_w) begin fails++; $display("FAIL fill_lane%0d got=%h exp=%h", k, out_data[16*k +: 16], exp_w); end
    end
    // Drain channels 1 and 6 only, then everything.
    out_ready = 8'h42;
    tick();
    checks++; if (out_valid !== 8'hBD) begin fails++; $display("FAIL partial_drain_valid got=%h exp=bd", out_valid); end
    checks++; if (occupancy !== 4'd6) begin fails++; $display("FAIL partial_drain_occupancy got=%0d exp=6", occupancy); end
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;
    checks++; if (out_valid !== 8'h00) begin fails++; $display("FAIL drain_out_valid got=%h exp=00", out_valid); end
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL drain_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_async_reset;
    do_reset();
    load(3'd1, 16'h0001);
    load(3'd4, 16'h0004);
    load(3'd6, 16'h0006);
    checks++; if (out_valid !== 8'h52) begin fails++; $display("FAIL ar_pre_valid got=%h exp=52", out_valid); end
    checks++; if (occupancy !== 4'd3) begin fails++; $display("FAIL ar_pre_occupancy got=%0d exp=3", occupancy); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 8'h00) begin fails++; $display("FAIL ar_out_valid got=%h exp=00", out_valid); end
    checks++; if (occupancy !== 4'd0) begin fails++; $display("FAIL ar_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 128'h0) begin fails++; $display("FAIL ar_out_data got=%h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    sel = 3'd2; in = 16'hFFFF; in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 8'h00) begin fails++; $display("FAIL ar_no_accept got=%h exp=00", out_valid); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    load(3'd7, 16'h7777);
    checks++; if (out_valid !== 8'h80) begin fails++; $display("FAIL ar_post_valid got=%h exp=80", out_valid); end
    checks++; if (occupancy !== 4'd1) begin fails++; $display("FAIL ar_post_occupancy got=%0d exp=1", occupancy); end
    checks++; if (out_data[127:112] !== 16'h7777) begin fails++; $display("FAIL ar_post_lane7 got=%h exp=7777", out_data[127:112]); end
  endtask

`ifdef MY_DMUX8WAY16_BCAST_EN
  task automatic test_broadcast;
    do_reset();
    bcast = 1'b1; sel = 3'd2; in = 16'hBEEF; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bc_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 8'hFF) begin fails++; $display("FAIL bc_out_valid got=%h exp=ff", out_valid); end
    checks++; if (occupancy !== 4'd8) begin fails++; $display("FAIL bc_occupancy got=%0d exp=8", occupancy); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_data[16*k +: 16] !== 16'hBEEF) begin fails++; $display("FAIL bc_lane%0d got=%h exp=beef", k, out_data[16*k +: 16]); end
    end
    // One blocked channel stalls a broadcast.
    out_ready = 8'hF7; in = 16'h1111; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bc_blocked_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0; bcast = 1'b0; out_ready = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_single_accept();
    test_idle();
    test_backpressure();
    test_pass_through();
    test_drain_all();
    test_async_reset();
`ifdef MY_DMUX8WAY16_BCAST_EN
    test_broadcast();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/my_dmux8way16_buf.md
MY_DMUX8WAY16_BUF -- requirements
Module: my_dmux8way16_buf

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in, input, 16 bits: input data word.
REQ-004 SHALL have port sel, input, 3 bits: destination channel index, 0..7.
REQ-005 SHALL have port in_valid, input, 1 bit: in and sel hold a valid word.
REQ-006 SHALL have port in_ready, output, 1 bit: word accepted this cycle when in_valid and in_ready are both high.
REQ-007 SHALL have port out_data, output, 128 bits: channel k data at bits [16k+15:16k].
REQ-008 SHALL have port out_valid, output, 8 bits: bit k high means channel k holds a word.
REQ-009 SHALL have port out_ready, input, 8 bits: bit k high means the channel k consumer takes the word.
REQ-010 SHALL have port occupancy, output, 4 bits: number of channels with out_valid set, 0..8.
REQ-011 SHALL have port bcast, input, 1 bit: broadcast request; present only when MY_DMUX8WAY16_BCAST_EN is defined.

Function
REQ-012 SHALL hold one 16-bit slot register and one valid flag per channel; out_data and out_valid SHALL be driven directly from these registers.
REQ-013 SHALL treat channel k as draining in a cycle when out_valid[k] and out_ready[k] are both high.
REQ-014 SHALL drive in_ready = !out_valid[sel] | out_ready[sel] (combinational); in_ready SHALL be independent of in_valid.
REQ-015 SHALL, on accept, load in into slot sel and set out_valid[sel] at the next edge; latency is 1 cycle.
REQ-016 SHALL, on simultaneous drain and accept of the same channel, replace the slot data and keep out_valid high, with no bubble.
REQ-017 SHALL clear out_valid[k] at the next edge when channel k drains with no new word for k.
REQ-018 SHALL hold slot data and valid unchanged while out_valid[k]=1 and out_ready[k]=0 (backpressure); other channels SHALL proceed independently.
REQ-019 SHALL leave slot data unchanged when the slot is empty and receives no load; out_data content is don't-care when out_valid is low.
REQ-020 SHALL register occupancy as the next-state popcount of the valid flags, so it always equals popcount(out_valid) in the same cycle.
REQ-021 SHALL make no state change when in_valid is low, regardless of sel.

Reset
REQ-022 SHALL, while rst_n=0, force out_valid=0, out_data=0 and occupancy=0 immediately, without waiting for a clock edge.
REQ-023 SHALL discard any held words when reset is asserted mid-operation; the first accept after rst_n deasserts SHALL behave as if from an empty state.
REQ-024 SHALL output in_ready=1 during reset, since all slots are empty; words are not accepted while rst_n=0.

Configuration
REQ-025 SHALL, with MY_DMUX8WAY16_BCAST_EN defined, add port bcast; when bcast=1, in_ready SHALL be the AND over all k of (!out_valid[k] | out_ready[k]), and sel SHALL be ignored.
REQ-026 SHALL, on a broadcast accept, load in into all 8 slots and set all out_valid bits; occupancy SHALL become 8 at the next edge.
REQ-027 SHALL, without MY_DMUX8WAY16_BCAST_EN, omit port bcast and all broadcast logic; behaviour SHALL match bcast=0.

Verification
REQ-028 SHALL cover: reset, then in=16'hA5A5, sel=3, in_valid=1 for one cycle -> next cycle out_valid=8'h08, out_data[63:48]=16'hA5A5, occupancy=1.
REQ-029 SHALL cover: channel 5 full with out_ready[5]=0, sel=5, in_valid=1 -> in_ready=0, no change; then sel=2 -> accepted, occupancy=2.
REQ-030 SHALL cover: channel 0 full, out_ready[0]=1, in=16'h1234, sel=0 -> in_ready=1; next cycle out_valid[0]=1, data=16'h1234, occupancy unchanged.
REQ-031 SHALL cover: all 8 channels loaded with distinct words, then out_ready=8'hFF with no input -> next cycle out_valid=0, occupancy=0.
REQ-032 SHALL cover: 3 channels full, rst_n pulsed low between clock edges -> out_valid=0 and occupancy=0 before the next edge.
REQ-033 SHALL cover, with MY_DMUX8WAY16_BCAST_EN defined: bcast=1, in=16'hBEEF, all channels empty -> next cycle out_valid=8'hFF, every lane=16'hBEEF, occupancy=8.
